// File: rtl/sdram_cmd_sequencer.sv
// rtl/sdram_cmd_sequencer.sv - SDRAM pin command sequencer with tRCD/tRP/tRFC/CL timing
// Optional RD_VALID output is enabled by defining SDRAM_RDVALID_EN.
module sdram_cmd_sequencer #(
  parameter int ASIZE    = 22,
  parameter int ROWSIZE  = 12,
  parameter int COLSIZE  = 8,
  parameter int BANKSIZE = 2,
  parameter int TRCD     = 3,
  parameter int TRP      = 3,
  parameter int TRFC     = 7,
  parameter int CL       = 3,
  parameter int BL       = 8
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                NOP,
  input  logic                READA,
  input  logic                WRITEA,
  input  logic                REFRESH,
  input  logic                PRECHARGE,
  input  logic                LOAD_MODE,
  input  logic [ASIZE-1:0]    SADDR,
  input  logic                REF_REQ,
  input  logic                INIT_DONE,
  output logic                CM_ACK,
  output logic                REF_ACK,
  output logic                OE,
  output logic [ROWSIZE-1:0]  SA,
  output logic [BANKSIZE-1:0] BA,
  output logic                CS_N,
  output logic                RAS_N,
  output logic                CAS_N,
  output logic                WE_N
`ifdef SDRAM_RDVALID_EN
  ,
  output logic                RD_VALID
`endif
);

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_LMR   = 4'b0000;

  localparam logic [4:0] LD_TRCD = 5'(TRCD - 1);
  localparam logic [4:0] LD_TRP  = 5'(TRP);
  localparam logic [4:0] LD_TRFC = 5'(TRFC - 1);
  localparam logic [4:0] LD_WR   = 5'(BL - 1);
  localparam logic [4:0] LD_RD   = 5'(CL + BL - 1);
  localparam logic [ROWSIZE-1:0] A10 = ROWSIZE'(1024);

  typedef enum logic [2:0] {IDLE, ACT_WAIT, RW, RD_WAIT, WR_BURST, PRE_WAIT, REF_WAIT} state_t;

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [ROWSIZE-1:0]  sa_q, sa_d;
  logic [BANKSIZE-1:0] ba_q, ba_d, bank_q, bank_d;
  logic [COLSIZE-1:0]  col_q, col_d;
  logic                is_wr_q, is_wr_d;
  logic                cm_ack_q, cm_ack_d, ref_ack_q, ref_ack_d, oe_q, oe_d;
  logic                last;
  logic                unused_nop;

  assign unused_nop = NOP;

  // Each wait state emits NOPs while the counter runs down; cnt_q<=1 marks the final one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != '0) ? cnt_q - 5'd1 : '0;
    cmd_d     = CMD_NOP;
    sa_d      = sa_q;
    ba_d      = ba_q;
    bank_d    = bank_q;
    col_d     = col_q;
    is_wr_d   = is_wr_q;
    cm_ack_d  = 1'b0;
    ref_ack_d = 1'b0;
    oe_d      = 1'b0;
    last      = (cnt_q <= 5'd1);
    case (state_q)
      IDLE: begin
        if (LOAD_MODE) begin
          cmd_d = CMD_LMR;
          sa_d  = SADDR[ROWSIZE-1:0];
          ba_d  = '0;
        end else if (PRECHARGE) begin
          cmd_d   = CMD_PRE;
          sa_d    = A10;
          ba_d    = '0;
          state_d = PRE_WAIT;
          cnt_d   = LD_TRP;
        end else if (REFRESH || (REF_REQ && INIT_DONE)) begin
          cmd_d     = CMD_REF;
          ref_ack_d = !REFRESH;
          state_d   = REF_WAIT;
          cnt_d     = LD_TRFC;
        end else if ((WRITEA || READA) && INIT_DONE) begin
          cmd_d   = CMD_ACT;
          is_wr_d = WRITEA;
          bank_d  = SADDR[ASIZE-1 -: BANKSIZE];
          col_d   = SADDR[COLSIZE-1:0];
          ba_d    = SADDR[ASIZE-1 -: BANKSIZE];
          sa_d    = SADDR[COLSIZE +: ROWSIZE];
          state_d = ACT_WAIT;
          cnt_d   = LD_TRCD;
        end
      end
      ACT_WAIT: if (last) state_d = RW;
      RW: begin
        cmd_d    = is_wr_q ? CMD_WRITE : CMD_READ;
        sa_d     = A10 | ROWSIZE'(col_q);
        ba_d     = bank_q;
        cm_ack_d = 1'b1;
        oe_d     = is_wr_q;
        state_d  = is_wr_q ? WR_BURST : RD_WAIT;
        cnt_d    = is_wr_q ? LD_WR : LD_RD;
      end
      WR_BURST: begin
        oe_d = 1'b1;
        if (last) begin
          state_d = PRE_WAIT;
          cnt_d   = LD_TRP;
        end
      end
      RD_WAIT: begin
        if (last) begin
          state_d = PRE_WAIT;
          cnt_d   = LD_TRP;
        end
      end
      PRE_WAIT, REF_WAIT: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_q     <= 4'b1111;
      sa_q      <= '0;
      ba_q      <= '0;
      bank_q    <= '0;
      col_q     <= '0;
      is_wr_q   <= 1'b0;
      cm_ack_q  <= 1'b0;
      ref_ack_q <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      sa_q      <= sa_d;
      ba_q      <= ba_d;
      bank_q    <= bank_d;
      col_q     <= col_d;
      is_wr_q   <= is_wr_d;
      cm_ack_q  <= cm_ack_d;
      ref_ack_q <= ref_ack_d;
      oe_q      <= oe_d;
    end
  end

  assign {CS_N, RAS_N, CAS_N, WE_N} = cmd_q;
  assign SA      = sa_q;
  assign BA      = ba_q;
  assign CM_ACK  = cm_ack_q;
  assign REF_ACK = ref_ack_q;
  assign OE      = oe_q;

`ifdef SDRAM_RDVALID_EN
  // RD_WAIT counts down from CL+BL-1; its last BL counts line up with returning read data.
  logic rd_valid_q, rd_valid_d;
  assign rd_valid_d = (state_q == RD_WAIT) && (cnt_q != '0) && (cnt_q <= 5'(BL));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rd_valid_q <= 1'b0;
    else          rd_valid_q <= rd_valid_d;
  end

  assign RD_VALID = rd_valid_q;
`endif

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// tb/tb_sdram_cmd_sequencer.sv - directed and randomized checks of sdram_cmd_sequencer
module tb_sdram_cmd_sequencer;
  localparam int TRCD = 3, TRP = 3, TRFC = 7, CL = 3, BL = 8;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_LMR = 4'b0000, C_DES = 4'b1111;

  logic CLK = 1'b0, RESET_N = 1'b0, NOP = 1'b0, READA = 1'b0, WRITEA = 1'b0;
  logic REFRESH = 1'b0, PRECHARGE = 1'b0, LOAD_MODE = 1'b0, REF_REQ = 1'b0, INIT_DONE = 1'b0;
  logic [21:0] SADDR = '0;
  logic CM_ACK, REF_ACK, OE, CS_N, RAS_N, CAS_N, WE_N;
  logic [11:0] SA;
  logic [1:0]  BA;
`ifdef SDRAM_RDVALID_EN
  logic RD_VALID;
`endif

  always #5 CLK = ~CLK;

  sdram_cmd_sequencer dut (
    .CLK(CLK), .RESET_N(RESET_N), .NOP(NOP), .READA(READA), .WRITEA(WRITEA),
    .REFRESH(REFRESH), .PRECHARGE(PRECHARGE), .LOAD_MODE(LOAD_MODE), .SADDR(SADDR),
    .REF_REQ(REF_REQ), .INIT_DONE(INIT_DONE), .CM_ACK(CM_ACK), .REF_ACK(REF_ACK), .OE(OE),
    .SA(SA), .BA(BA), .CS_N(CS_N), .RAS_N(RAS_N), .CAS_N(CAS_N), .WE_N(WE_N)
`ifdef SDRAM_RDVALID_EN
    , .RD_VALID(RD_VALID)
`endif
  );

  typedef struct {
    logic [3:0]  cmd;
    logic [11:0] sa, sa_m;
    logic [1:0]  ba, ba_m;
    logic        cm, ra, oe, rdv;
  } exp_t;

  exp_t q[$];
  int passed = 0, total = 0, cyc = 0;
  int hold_cfg = 0, hold_left = 0;
  bit rw_pend = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void push(input logic [3:0] cmd, input logic [11:0] sa, input logic [11:0] sa_m,
                               input logic [1:0] ba, input logic [1:0] ba_m,
                               input logic cm, input logic ra, input logic oe, input logic rdv);
    exp_t e;
    e.cmd = cmd; e.sa = sa; e.sa_m = sa_m; e.ba = ba; e.ba_m = ba_m;
    e.cm = cm; e.ra = ra; e.oe = oe; e.rdv = rdv;
    q.push_back(e);
  endfunction

  function automatic void m_nop(input int n);
    for (int i = 0; i < n; i++) push(C_NOP, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void m_ref(input logic ack);
    push(C_REF, 0, 0, 0, 0, 0, ack, 0, 0);
    m_nop(TRFC - 1);
  endfunction

  function automatic void m_pre();
    push(C_PRE, 12'h400, 12'h400, 0, 0, 0, 0, 0, 0);
    m_nop(TRP);
  endfunction

  function automatic void m_lmr(input logic [21:0] a);
    push(C_LMR, a[11:0], 12'hFFF, 2'd0, 2'b11, 0, 0, 0, 0);
  endfunction

  // Expected pin trace of one READA/WRITEA: ACT, tRCD gap, command, data phase, tRP.
  function automatic void m_rw(input logic wr, input logic [21:0] a);
    logic [1:0]  bank;
    logic [11:0] row, rwsa;
    bank = a[21:20];
    row  = a[19:8];
    rwsa = 12'h400 | {4'h0, a[7:0]};
    push(C_ACT, row, 12'hFFF, bank, 2'b11, 0, 0, 0, 0);
    m_nop(TRCD - 1);
    push(wr ? C_WR : C_RD, rwsa, 12'h4FF, bank, 2'b11, 1, 0, wr, 0);
    if (wr) for (int k = 1; k < BL; k++) push(C_NOP, 0, 0, 0, 0, 0, 0, 1, 0);
    else    for (int k = 1; k < CL + BL; k++) push(C_NOP, 0, 0, 0, 0, 0, 0, 0, logic'(k >= CL));
    m_nop(TRP);
  endfunction

  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      tick();
      e = q.pop_front();
      REFRESH = 0; PRECHARGE = 0; LOAD_MODE = 0;
      chk("cmd", 32'({CS_N, RAS_N, CAS_N, WE_N}), 32'(e.cmd));
      chk("cm_ack", 32'(CM_ACK), 32'(e.cm));
      chk("ref_ack", 32'(REF_ACK), 32'(e.ra));
      chk("oe", 32'(OE), 32'(e.oe));
`ifdef SDRAM_RDVALID_EN
      chk("rd_valid", 32'(RD_VALID), 32'(e.rdv));
`endif
      if (e.sa_m != 0) chk("sa", 32'(SA & e.sa_m), 32'(e.sa & e.sa_m));
      if (e.ba_m != 0) chk("ba", 32'(BA & e.ba_m), 32'(e.ba & e.ba_m));
      if (e.ra) REF_REQ = 0;
      if (e.cm) begin rw_pend = 1; hold_left = hold_cfg; end
      if (rw_pend) begin
        if (hold_left == 0) begin READA = 0; WRITEA = 0; rw_pend = 0; end
        else hold_left--;
      end
    end
  endtask

  task automatic chk_reset_pins();
    chk("rst_cmd", 32'({CS_N, RAS_N, CAS_N, WE_N}), 32'(C_DES));
    chk("rst_sa", 32'(SA), 0);
    chk("rst_ba", 32'(BA), 0);
    chk("rst_acks", 32'({CM_ACK, REF_ACK, OE}), 0);
  endtask

  initial begin
    logic [21:0] a;
    int mode, k;
    logic wr;
    tick(); tick();
    chk_reset_pins();
    RESET_N = 1;

    // Requests are ignored until INIT_DONE.
    READA = 1; SADDR = 22'h12345;
    m_nop(3); run(100);
    READA = 0;

    PRECHARGE = 1; m_pre(); run(100);
    REFRESH = 1; m_ref(0); run(100);
    REFRESH = 1; m_ref(0); run(100);
    LOAD_MODE = 1; SADDR = 22'h037; m_lmr(SADDR); m_nop(2); run(100);

    INIT_DONE = 1;
    hold_cfg = 0;
    WRITEA = 1; SADDR = 22'h2ABCD; m_rw(1, SADDR); m_nop(2); run(100);

    READA = 1; REF_REQ = 1; SADDR = 22'h1F00E; m_ref(1); m_rw(0, SADDR); run(100);

    hold_cfg = 3;
    READA = 1; SADDR = 22'h3C3A5; m_rw(0, SADDR); m_nop(4); run(100);
    hold_cfg = 0;

    // Asynchronous reset in the middle of a write burst.
    WRITEA = 1; SADDR = 22'h05A5A; m_rw(1, SADDR); run(6);
    RESET_N = 0;
    #1;
    chk_reset_pins();
    WRITEA = 0; q.delete(); rw_pend = 0;
    tick(); tick();
    chk_reset_pins();
    RESET_N = 1;
    READA = 1; SADDR = 22'h2FEDC; m_rw(0, SADDR); run(100);

    for (int it = 0; it < 24; it++) begin
      wr = logic'($urandom_range(0, 1));
      a = 22'($urandom);
      mode = $urandom_range(0, 3);
      hold_cfg = $urandom_range(0, 3);
      m_nop($urandom_range(0, 3)); run(100);
      SADDR = a;
      if (mode == 3) begin
        LOAD_MODE = 1; m_lmr(a); run(100);
        a = 22'($urandom); SADDR = a;
      end
      if (wr) WRITEA = 1; else READA = 1;
      if (mode == 1) begin
        REF_REQ = 1; m_ref(1); m_rw(wr, a); run(100);
      end else if (mode == 2) begin
        m_rw(wr, a); m_ref(1);
        k = $urandom_range(1, 10);
        run(k);
        REF_REQ = 1;
        run(100);
      end else begin
        m_rw(wr, a); run(100);
      end
    end
    m_nop(3); run(100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d observed=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end
endmodule
